// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
//   Shared configuration and helpers for the binary-weight convolution window.
//   DATA_WIDTH / K / LOGK are the single point of configuration; the interface,
//   the top level and the bench all derive their widths from here.
//
//   Contents:
//     DATA_WIDTH  width of one signed activation
//     K           kernel side (window is K x K)
//     LOGK        result growth bits, >= ceil(log2(K*K))
//     ACC_W       result width, DATA_WIDTH + LOGK
//     N           number of window elements, K*K
//     sign_term   sign-extend an activation to ACC_W and apply its +/-1 weight
// -----------------------------------------------------------------------------
package bnn_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int K          = 4;
  localparam int LOGK       = 4;
  localparam int ACC_W      = DATA_WIDTH + LOGK;
  localparam int N          = K * K;

  // Sign extension happens before the negate so that -x is formed at full
  // accumulator width. With x = -2^(DATA_WIDTH-1) excluded upstream, -x
  // always fits; if it does appear, the result simply wraps.
  function automatic logic signed [ACC_W-1:0] sign_term(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic                         w
  );
    logic signed [ACC_W-1:0] xe;
    xe = {{LOGK{x[DATA_WIDTH-1]}}, x};
    return w ? xe : -xe;
  endfunction

endpackage

// File: rtl/bnn_conv_if.sv
// -----------------------------------------------------------------------------
// bnn_conv_if
//   Window bus between the line-buffer window generator, the convolution
//   window and the downstream activation/threshold stage.
//
//   Signals:
//     ivalid  window request qualifier (upstream -> conv)
//     idata   N packed signed activations, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//     weight  N weight bits, weight[i] pairs with element i (1 = +1, 0 = -1)
//     ovalid  result qualifier (conv -> downstream)
//     dout    signed window sum, ACC_W bits, two's complement
//
//   Handshake: valid-only, no ready. A window is transferred on every rising
//   clk edge where ivalid=1; the conv block can always accept one window per
//   cycle and downstream must always accept a result in any cycle where
//   ovalid=1. idata/weight are ignored when ivalid=0, and dout carries no
//   meaning when ovalid=0.
//
//   Modports:
//     master  upstream/testbench side (drives ivalid/idata/weight)
//     slave   convolution window side (drives ovalid/dout)
// -----------------------------------------------------------------------------
interface bnn_conv_if;
  import bnn_pkg::*;

  logic                         ivalid;
  logic [N*DATA_WIDTH-1:0]      idata;
  logic [N-1:0]                 weight;
  logic                         ovalid;
  logic [ACC_W-1:0]             dout;

  modport master (
    output ivalid,
    output idata,
    output weight,
    input  ovalid,
    input  dout
  );

  modport slave (
    input  ivalid,
    input  idata,
    input  weight,
    output ovalid,
    output dout
  );

endinterface

// File: rtl/bnn_add_tree.sv
// -----------------------------------------------------------------------------
// bnn_add_tree
//   N-input signed balanced adder tree, purely combinational.
//   The tree is split after its first level so the caller can either wire the
//   level-1 partial sums straight back in or put a register stage between
//   them.
//
//   Parameters:
//     N  number of input operands (>= 1)
//     W  operand and result width (all arithmetic is modulo 2^W)
//
//   Ports:
//     terms   in   [N] x W   signed input operands
//     l1_out  out  [M] x W   level-1 partial sums, M = ceil(N/2)
//     l1_in   in   [M] x W   level-1 partial sums feeding the rest of the tree
//     sum     out  W         sum of all l1_in entries
//
//   An odd operand at any level is passed to the next level unchanged.
// -----------------------------------------------------------------------------
module bnn_add_tree #(
  parameter  int N = 16,
  parameter  int W = 8,
  localparam int M = (N + 1) / 2
) (
  input  logic signed [W-1:0] terms  [N],
  output logic signed [W-1:0] l1_out [M],
  input  logic signed [W-1:0] l1_in  [M],
  output logic signed [W-1:0] sum
);

  // Number of entries at reduction level k, counting l1_in as level 0.
  function automatic int lvl_cnt(input int k);
    int c;
    c = M;
    for (int i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Offset of level k inside the flat node array.
  function automatic int lvl_off(input int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o = o + lvl_cnt(i);
    return o;
  endfunction

  // R levels of reduction after level 1; the final node holds the total.
  localparam int R = $clog2(M);
  localparam int T = lvl_off(R) + 1;

  // First level: pair neighbours, odd tail passes through.
  always_comb begin
    for (int j = 0; j < M; j++) begin
      if (2 * j + 1 < N) begin
        l1_out[j] = terms[2*j] + terms[2*j+1];
      end else begin
        l1_out[j] = terms[2*j];
      end
    end
  end

  // Remaining levels share one flat node array. Levels are laid out back to
  // back: [level0 | level1 | ... | root]. Loops use the static bound M and a
  // guard so they unroll to a fixed structure.
  logic signed [W-1:0] nd [T];

  always_comb begin
    int src;
    int dst;
    int sn;
    int dn;

    for (int i = 0; i < T; i++) nd[i] = '0;
    for (int j = 0; j < M; j++) nd[j] = l1_in[j];

    src = 0;
    dst = M;
    sn  = M;
    for (int k = 0; k < R; k++) begin
      dn = (sn + 1) / 2;
      for (int j = 0; j < M; j++) begin
        if (j < dn) begin
          if (2 * j + 1 < sn) begin
            nd[dst+j] = nd[src+2*j] + nd[src+2*j+1];
          end else begin
            nd[dst+j] = nd[src+2*j];
          end
        end
      end
      src = dst;
      dst = dst + dn;
      sn  = dn;
    end
  end

  assign sum = nd[T-1];

endmodule

// File: rtl/bnn_conv.sv
// -----------------------------------------------------------------------------
// bnn_conv
//   Binary-weight K x K convolution window. Every activation is added when its
//   weight bit is 1 and subtracted when it is 0; the N signed terms are summed
//   by a balanced adder tree into one signed result per window.
//
//   Ports:
//     clk   in  clock
//     rstn  in  asynchronous active-low reset; clears the result, ovalid and
//               any in-flight pipeline state immediately
//     bus   slave side of bnn_conv_if (ivalid/idata/weight in, ovalid/dout out)
//
//   Timing: one window accepted per cycle, no backpressure.
//     CONV_PIPE_EN undefined: tree is combinational into the output register,
//                             latency 1 cycle.
//     CONV_PIPE_EN defined:   a register stage sits after the first tree
//                             level, latency 2 cycles, ovalid delayed to match.
//   Datapath registers load every cycle regardless of ivalid; only ovalid
//   marks a meaningful dout.
// -----------------------------------------------------------------------------
module bnn_conv
  import bnn_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  bnn_conv_if.slave  bus
);

  localparam int M1 = (N + 1) / 2;

  logic signed [ACC_W-1:0] terms  [N];
  logic signed [ACC_W-1:0] l1_out [M1];
  logic signed [ACC_W-1:0] l1_in  [M1];
  logic signed [ACC_W-1:0] sum;
  logic                    valid_d;

  logic [ACC_W-1:0]        dout_q;
  logic                    ovalid_q;

  // Per-element signed term.
  for (genvar i = 0; i < N; i++) begin : g_term
    assign terms[i] = sign_term(bus.idata[i*DATA_WIDTH +: DATA_WIDTH], bus.weight[i]);
  end

  bnn_add_tree #(
    .N (N),
    .W (ACC_W)
  ) u_tree (
    .terms  (terms),
    .l1_out (l1_out),
    .l1_in  (l1_in),
    .sum    (sum)
  );

`ifdef CONV_PIPE_EN
  // Level-1 partial sums and their qualifier are registered; the rest of
  // the tree then feeds the output register one cycle later.
  logic signed [ACC_W-1:0] l1_q [M1];
  logic                    v_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < M1; j++) l1_q[j] <= '0;
      v_q <= 1'b0;
    end else begin
      for (int j = 0; j < M1; j++) l1_q[j] <= l1_out[j];
      v_q <= bus.ivalid;
    end
  end

  assign l1_in   = l1_q;
  assign valid_d = v_q;
`else
  assign l1_in   = l1_out;
  assign valid_d = bus.ivalid;
`endif

  // Output register: dout is loaded every edge; ovalid alone qualifies it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      dout_q   <= sum;
      ovalid_q <= valid_d;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.ovalid = ovalid_q;

endmodule

// File: tb/tb_bnn_conv.sv
// -----------------------------------------------------------------------------
// tb_bnn_conv
//   Testbench for bnn_conv. Table vectors for the fixed-pattern cases, random
//   windows with ivalid toggling, and a hand-written mid-stream reset sequence.
//   Expected sums come from an integer reference model; a queue holds each
//   expected result with the cycle it must appear on.
// -----------------------------------------------------------------------------
module tb_bnn_conv;
  import bnn_pkg::*;

`ifdef CONV_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bnn_conv_if bus ();

  bnn_conv dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [ACC_W-1:0] exp_q[$];
  int               cyc_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  logic             mon_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [ACC_W-1:0] ref_sum(input logic [N*DATA_WIDTH-1:0] d,
                                               input logic [N-1:0] w);
    int s;
    logic signed [DATA_WIDTH-1:0] e;
    s = 0;
    for (int i = 0; i < N; i++) begin
      e = d[i*DATA_WIDTH +: DATA_WIDTH];
      if (w[i]) s = s + int'(e);
      else      s = s - int'(e);
    end
    return ACC_W'(s);
  endfunction

  function automatic logic [N*DATA_WIDTH-1:0] rep(input logic [DATA_WIDTH-1:0] v);
    logic [N*DATA_WIDTH-1:0] r;
    for (int i = 0; i < N; i++) r[i*DATA_WIDTH +: DATA_WIDTH] = v;
    return r;
  endfunction

  function automatic logic [N*DATA_WIDTH-1:0] rand_window();
    logic [N*DATA_WIDTH-1:0] r;
    int v;
    for (int i = 0; i < N; i++) begin
      v = int'($urandom_range(0, 14)) - 7;  // -7..7, code -8 excluded
      r[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(v);
    end
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [N*DATA_WIDTH-1:0] d,
                       input logic [N-1:0] w, input logic [ACC_W-1:0] e);
    @(negedge clk);
    bus.ivalid = v;
    bus.idata  = d;
    bus.weight = w;
    if (v) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc + LAT);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [ACC_W-1:0] e;
    int               c;
    if (rstn && mon_en) begin
      if (bus.ovalid) begin
        if (exp_q.size() == 0) begin
          check("spurious_ovalid", 32'(bus.ovalid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          check("ovalid_cycle", 32'(cyc), 32'(c));
          check("dout", 32'(bus.dout), 32'(e));
        end
      end else if (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
        check("missing_ovalid", 32'(bus.ovalid), 32'd1);
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [N*DATA_WIDTH-1:0] d;
    logic [N-1:0]            w;
    logic [ACC_W-1:0]        e;
  } vec_t;

  vec_t tbl [7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [N*DATA_WIDTH-1:0] d;
    logic [N-1:0]            w;

    bus.ivalid = 1'b0;
    bus.idata  = '0;
    bus.weight = '0;

    tbl[0] = '{d: rep(4'h1), w: 16'hFFFF, e: 8'h10};  // +16
    tbl[1] = '{d: rep(4'h1), w: 16'h0000, e: 8'hF0};  // -16
    tbl[2] = '{d: rep(4'h7), w: 16'h00FF, e: 8'h00};  // 0
    tbl[3] = '{d: rep(4'h9), w: 16'hFFFF, e: 8'h90};  // -112
    tbl[4] = '{d: rep(4'h7), w: 16'hFFFF, e: 8'h70};  // +112
    tbl[5] = '{d: rep(4'h9), w: 16'h0000, e: 8'h70};  // +112
    tbl[6] = '{d: rep(4'h8), w: 16'h0000, e: 8'h80};  // excluded code wraps: +128 -> -128

    // Reset state.
    #12;
    check("reset_dout", 32'(bus.dout), 32'd0);
    check("reset_ovalid", 32'(bus.ovalid), 32'd0);
    @(negedge clk);
    rstn   = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Fixed patterns back to back.
    for (int i = 0; i < 7; i++) drive(1'b1, tbl[i].d, tbl[i].w, tbl[i].e);
    idle(LAT + 1);

    // Random windows, ivalid toggling.
    for (int i = 0; i < 1000; i++) begin
      d = rand_window();
      w = N'($urandom_range(0, 16'hFFFF));
      drive(1'($urandom_range(0, 1)), d, w, ref_sum(d, w));
    end

    // Mid-stream asynchronous reset.
    for (int i = 0; i < LAT + 1; i++) drive(1'b1, tbl[0].d, tbl[0].w, tbl[0].e);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_dout", 32'(bus.dout), 32'd0);
    check("async_rst_ovalid", 32'(bus.ovalid), 32'd0);
    exp_q.delete();
    cyc_q.delete();
    bus.ivalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_dout", 32'(bus.dout), 32'd0);
    check("held_rst_ovalid", 32'(bus.ovalid), 32'd0);
    @(negedge clk);
    bus.ivalid = 1'b0;
    rstn       = 1'b1;
    idle(3);
    drive(1'b1, tbl[4].d, tbl[4].w, tbl[4].e);
    idle(LAT + 2);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
